reservation_station: RTL and testbench

// - Unified reservation station directly downstream of dispatch. Buffers disp_packet_t entries

---
 rtl/reservation_station_pkg.sv | 30 +++
 rtl/reservation_station_oldest_select.sv | 33 +++
 rtl/reservation_station.sv | 170 +++++++++++++++++
 tb/tb_reservation_station.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types and sizing for the reservation station slice.
// Contents:
//   RS_DEPTH, PREG_COUNT, PREG_W, NUM_FUS, WAKEUP_PORTS  default sizing
//   disp_packet_t  packet produced by dispatch and carried to the FU side
//   rs_entry_t     one station slot: packet, per-source ready bits, valid
package reservation_station_pkg;

  localparam int RS_DEPTH     = 4;
  localparam int PREG_COUNT   = 64;
  localparam int PREG_W       = $clog2(PREG_COUNT);
  localparam int NUM_FUS      = 4;
  localparam int WAKEUP_PORTS = NUM_FUS;

  typedef struct packed {
    logic              instr_valid;
    logic [31:0]       pc;
    logic [3:0]        fu_op;
    logic [PREG_W-1:0] src1_preg;
    logic [PREG_W-1:0] src2_preg;
    logic [PREG_W-1:0] dst_preg;
  } disp_packet_t;

  typedef struct packed {
    disp_packet_t pkt;
    logic         src1_rdy;
    logic         src2_rdy;
    logic         valid;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_oldest_select.sv
// rs_oldest_select: picks the oldest requesting slot using an age matrix.
// Ports:
//   req_i    [N]      slots that are eligible this cycle
//   older_i  [N][N]   older_i[j][c] = 1 when slot j was allocated before slot c
//   gnt_o    [N]      one-hot grant of the oldest requester (0 when none)
//   any_o             at least one slot requests
// Purely combinational so per-FU stations can reuse it unchanged.
module rs_oldest_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]        req_i,
  input  logic [N-1:0][N-1:0] older_i,
  output logic [N-1:0]        gnt_o,
  output logic                any_o
);

  // A requester wins when no other requester is older than it; with a strict
  // total order among valid slots exactly one survives.
  always_comb begin
    gnt_o = '0;
    for (int c = 0; c < N; c++) begin
      gnt_o[c] = req_i[c];
      for (int j = 0; j < N; j++) begin
        if (j != c && req_i[j] && older_i[j][c]) begin
          gnt_o[c] = 1'b0;
        end
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/reservation_station.sv
// reservation_station: unified RS between dispatch and the functional units.
// Holds dispatched packets until both source pregs are ready, then offers the
// oldest ready one for issue.
// Ports:
//   clk, rst           core clock, asynchronous active-high reset
//   disp_pkt_i         dispatched packet, instr_valid is the request
//   disp_src1_rdy_i    src1 ready at dispatch (busy-table read)
//   disp_src2_rdy_i    src2 ready at dispatch
//   disp_ready_o       a packet can be accepted this cycle
//   wakeup_valid_i     per-port wakeup broadcast valid
//   wakeup_preg_i      per-port preg tag becoming ready
//   issue_valid_o      issue_pkt_o holds a ready entry
//   issue_pkt_o        oldest ready packet ('0 when issue_valid_o is low)
//   issue_ready_i      FU accepts this cycle
//   flush_i            discard every entry
//   occupancy_o        number of valid entries
// NUM_PREGS must match the tag width carried in disp_packet_t.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_ENTRIES = RS_DEPTH,
  parameter int NUM_PREGS  = PREG_COUNT,
  parameter int NUM_WAKEUP = WAKEUP_PORTS,
  localparam int PW        = $clog2(NUM_PREGS),
  localparam int OW        = $clog2(RS_ENTRIES + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  disp_packet_t                     disp_pkt_i,
  input  logic                             disp_src1_rdy_i,
  input  logic                             disp_src2_rdy_i,
  output logic                             disp_ready_o,
  input  logic [NUM_WAKEUP-1:0]            wakeup_valid_i,
  input  logic [NUM_WAKEUP-1:0][PW-1:0]    wakeup_preg_i,
  output logic                             issue_valid_o,
  output disp_packet_t                     issue_pkt_o,
  input  logic                             issue_ready_i,
  input  logic                             flush_i,
  output logic [OW-1:0]                    occupancy_o
);

  localparam logic [OW-1:0] FULL = OW'(RS_ENTRIES);

  rs_entry_t                           entries_q [RS_ENTRIES];
  rs_entry_t                           entries_d [RS_ENTRIES];
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older_q, older_d;
  logic [OW-1:0]                       occ_q, occ_d;

  logic [RS_ENTRIES-1:0] valid_vec;
  logic [RS_ENTRIES-1:0] cand;
  logic [RS_ENTRIES-1:0] gnt;
  logic [RS_ENTRIES-1:0] alloc_oh;
  logic                  alloc_found;
  logic                  any_cand;
  logic                  disp_fire;
  logic                  issue_fire;

  // True when any valid wakeup port broadcasts this tag.
  function automatic logic tag_hit(input logic [PW-1:0]                 tag,
                                   input logic [NUM_WAKEUP-1:0]         vld,
                                   input logic [NUM_WAKEUP-1:0][PW-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < NUM_WAKEUP; w++) begin
      if (vld[w] && tags[w] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [OW-1:0] count_ones(input logic [RS_ENTRIES-1:0] v);
    logic [OW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < RS_ENTRIES; i++) cnt = cnt + OW'(v[i]);
    return cnt;
  endfunction

  always_comb begin
    valid_vec = '0;
    cand      = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      cand[i]      = entries_q[i].valid && entries_q[i].src1_rdy && entries_q[i].src2_rdy;
    end
  end

  rs_oldest_select #(.N(RS_ENTRIES)) u_select (
    .req_i   (cand),
    .older_i (older_q),
    .gnt_o   (gnt),
    .any_o   (any_cand)
  );

  // Readiness comes from registered occupancy only; a same-cycle issue does
  // not make room for a dispatch.
  assign disp_ready_o  = (occ_q < FULL);
  assign disp_fire     = disp_pkt_i.instr_valid && disp_ready_o && !flush_i;
  assign issue_valid_o = any_cand && !flush_i;
  assign issue_fire    = issue_valid_o && issue_ready_i;
  assign occupancy_o   = occ_q;

  always_comb begin
    issue_pkt_o = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (issue_valid_o && gnt[i]) issue_pkt_o = entries_q[i].pkt;
    end
  end

  // Lowest-index free slot.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!entries_q[i].valid && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  always_comb begin
    older_d = older_q;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        entries_d[i].src1_rdy = entries_q[i].src1_rdy ||
                                tag_hit(entries_q[i].pkt.src1_preg, wakeup_valid_i, wakeup_preg_i);
        entries_d[i].src2_rdy = entries_q[i].src2_rdy ||
                                tag_hit(entries_q[i].pkt.src2_preg, wakeup_valid_i, wakeup_preg_i);
      end
      if (issue_fire && gnt[i]) entries_d[i].valid = 1'b0;
      // Same-cycle wakeups are folded into the incoming packet so none is lost.
      if (disp_fire && alloc_oh[i]) begin
        entries_d[i].pkt      = disp_pkt_i;
        entries_d[i].src1_rdy = disp_src1_rdy_i ||
                                tag_hit(disp_pkt_i.src1_preg, wakeup_valid_i, wakeup_preg_i);
        entries_d[i].src2_rdy = disp_src2_rdy_i ||
                                tag_hit(disp_pkt_i.src2_preg, wakeup_valid_i, wakeup_preg_i);
        entries_d[i].valid    = 1'b1;
        // New slot is younger than everything currently held.
        older_d[i] = '0;
        for (int j = 0; j < RS_ENTRIES; j++) begin
          older_d[j][i] = entries_q[j].valid;
        end
      end
      if (flush_i) entries_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    occ_d = occ_q + OW'(disp_fire) - OW'(issue_fire);
    if (flush_i) occ_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_ENTRIES; i++) entries_q[i] <= '0;
      older_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) entries_q[i] <= entries_d[i];
      older_q <= older_d;
      occ_q   <= occ_d;
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ_q <= FULL);
  a_occ_match: assert property (@(posedge clk) disable iff (rst) occ_q == count_ones(valid_vec));
  a_no_under:  assert property (@(posedge clk) disable iff (rst) !(issue_fire && occ_q == '0));

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic                          clk;
  logic                          rst;
  disp_packet_t                  disp_pkt;
  logic                          disp_src1_rdy, disp_src2_rdy;
  logic                          disp_ready;
  logic [WAKEUP_PORTS-1:0]       wk_valid;
  logic [WAKEUP_PORTS-1:0][PREG_W-1:0] wk_preg;
  logic                          issue_valid;
  disp_packet_t                  issue_pkt;
  logic                          issue_ready;
  logic                          flush;
  logic [2:0]                    occupancy;

  int checks = 0;
  int errors = 0;

  reservation_station dut (
    .clk             (clk),
    .rst             (rst),
    .disp_pkt_i      (disp_pkt),
    .disp_src1_rdy_i (disp_src1_rdy),
    .disp_src2_rdy_i (disp_src2_rdy),
    .disp_ready_o    (disp_ready),
    .wakeup_valid_i  (wk_valid),
    .wakeup_preg_i   (wk_preg),
    .issue_valid_o   (issue_valid),
    .issue_pkt_o     (issue_pkt),
    .issue_ready_i   (issue_ready),
    .flush_i         (flush),
    .occupancy_o     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [31:0] pc, input logic [PREG_W-1:0] s1,
                      input logic [PREG_W-1:0] s2, input logic r1, input logic r2);
    disp_pkt             = '0;
    disp_pkt.instr_valid = 1'b1;
    disp_pkt.pc          = pc;
    disp_pkt.src1_preg   = s1;
    disp_pkt.src2_preg   = s2;
    disp_src1_rdy        = r1;
    disp_src2_rdy        = r2;
  endtask

  task automatic no_disp();
    disp_pkt      = '0;
    disp_src1_rdy = 1'b0;
    disp_src2_rdy = 1'b0;
  endtask

  task automatic no_wake();
    wk_valid = '0;
    wk_preg  = '0;
  endtask

  initial begin
    rst = 1'b1;
    issue_ready = 1'b0;
    flush = 1'b0;
    no_disp();
    no_wake();
    step();
    step();
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_issue_pkt", 64'(issue_pkt), 64'd0);
    rst = 1'b0;
    step();

    // Single ready packet issues the cycle after dispatch.
    disp(32'h100, 6'd5, 6'd6, 1'b1, 1'b1);
    step();
    no_disp();
    chk("basic_issue_valid", 64'(issue_valid), 64'd1);
    chk("basic_pc", 64'(issue_pkt.pc), 64'h100);
    chk("basic_occ1", 64'(occupancy), 64'd1);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("basic_occ0", 64'(occupancy), 64'd0);
    chk("basic_idle", 64'(issue_valid), 64'd0);

    // Older A waits on preg 7, younger B ready; once A wakes it wins.
    disp(32'h200, 6'd7, 6'd8, 1'b0, 1'b1);
    step();
    disp(32'h204, 6'd10, 6'd11, 1'b1, 1'b1);
    step();
    no_disp();
    chk("age_b_shown", 64'(issue_pkt.pc), 64'h204);
    wk_valid[2] = 1'b1;
    wk_preg[2]  = 6'd7;
    step();
    no_wake();
    chk("age_a_first", 64'(issue_pkt.pc), 64'h200);
    issue_ready = 1'b1;
    step();
    chk("age_b_next", 64'(issue_pkt.pc), 64'h204);
    chk("age_occ1", 64'(occupancy), 64'd1);
    step();
    issue_ready = 1'b0;
    chk("age_occ0", 64'(occupancy), 64'd0);

    // Fill, reject a fifth packet, wake all, drain in dispatch order.
    for (int i = 0; i < 4; i++) begin
      disp(32'h300 + 32'(4 * i), 6'(20 + i), 6'(30 + i), 1'b0, 1'b1);
      step();
    end
    no_disp();
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_not_ready", 64'(disp_ready), 64'd0);
    chk("full_no_issue", 64'(issue_valid), 64'd0);
    disp(32'h400, 6'd1, 6'd1, 1'b1, 1'b1);
    step();
    no_disp();
    chk("full_fifth_ignored", 64'(occupancy), 64'd4);
    chk("full_fifth_no_issue", 64'(issue_valid), 64'd0);
    for (int w = 0; w < 4; w++) begin
      wk_valid[w] = 1'b1;
      wk_preg[w]  = 6'(20 + w);
    end
    step();
    no_wake();
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(issue_valid), 64'd1);
      chk("drain_pc", 64'(issue_pkt.pc), 64'h300 + 64'(4 * i));
      if (i == 0) begin
        chk("drain_full_ready", 64'(disp_ready), 64'd0);
        disp(32'h500, 6'd2, 6'd2, 1'b1, 1'b1);
      end
      issue_ready = 1'b1;
      step();
      no_disp();
    end
    issue_ready = 1'b0;
    chk("drain_occ0", 64'(occupancy), 64'd0);
    chk("drain_idle", 64'(issue_valid), 64'd0);

    // Wakeup in the same cycle as dispatch is not lost.
    disp(32'h600, 6'd9, 6'd12, 1'b0, 1'b1);
    wk_valid[0] = 1'b1;
    wk_preg[0]  = 6'd9;
    step();
    no_disp();
    no_wake();
    chk("samecyc_valid", 64'(issue_valid), 64'd1);
    chk("samecyc_pc", 64'(issue_pkt.pc), 64'h600);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("samecyc_occ0", 64'(occupancy), 64'd0);

    // src1 == src2: one matching tag readies both sources.
    disp(32'h700, 6'd13, 6'd13, 1'b0, 1'b0);
    step();
    no_disp();
    chk("dup_wait", 64'(issue_valid), 64'd0);
    wk_valid[3] = 1'b1;
    wk_preg[3]  = 6'd13;
    step();
    no_wake();
    chk("dup_valid", 64'(issue_valid), 64'd1);
    chk("dup_pc", 64'(issue_pkt.pc), 64'h700);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("dup_occ0", 64'(occupancy), 64'd0);

    // Flush with concurrent dispatch and issue request.
    disp(32'h810, 6'd3, 6'd4, 1'b1, 1'b1);
    step();
    disp(32'h814, 6'd41, 6'd42, 1'b0, 1'b1);
    step();
    disp(32'h818, 6'd43, 6'd44, 1'b0, 1'b1);
    step();
    chk("pre_flush_occ", 64'(occupancy), 64'd3);
    chk("pre_flush_valid", 64'(issue_valid), 64'd1);
    disp(32'h800, 6'd1, 6'd2, 1'b1, 1'b1);
    flush = 1'b1;
    issue_ready = 1'b1;
    #1;
    chk("flush_mask_valid", 64'(issue_valid), 64'd0);
    chk("flush_mask_pkt", 64'(issue_pkt), 64'd0);
    step();
    flush = 1'b0;
    issue_ready = 1'b0;
    no_disp();
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_issue", 64'(issue_valid), 64'd0);
    chk("flush_disp_ready", 64'(disp_ready), 64'd1);

    // Asynchronous reset mid-operation.
    disp(32'h900, 6'd1, 6'd2, 1'b1, 1'b1);
    step();
    no_disp();
    chk("arst_pre_occ", 64'(occupancy), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_issue", 64'(issue_valid), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("arst_after", 64'(issue_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
